// File: rtl/atom_pkg.sv
// Shared RV32 decode definitions: opcode constants, decoded-entry layout and
// the decode-stage occupancy states.
package atom_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic r;
        logic i;
        logic s;
        logic b;
        logic u;
        logic j;
    } fmt_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        fmt_t            fmt;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_MAIN  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and downstream handshake bundle for decode_stage.
// master = surrounding pipeline (fetch + consumer), slave = decode_stage.
interface decode_stage_if;
    import atom_pkg::*;

    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_instruction;
    logic [XLEN-1:0] if_pc;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_instruction;
    logic [XLEN-1:0] id_pc;
    logic            is_type_R;
    logic            is_type_I;
    logic            is_type_S;
    logic            is_type_B;
    logic            is_type_U;
    logic            is_type_J;
    logic            id_illegal;

    modport master (
        output if_valid, if_instruction, if_pc, id_ready,
        input  if_ready, id_valid, id_instruction, id_pc,
        input  is_type_R, is_type_I, is_type_S, is_type_B, is_type_U, is_type_J,
        input  id_illegal
    );

    modport slave (
        input  if_valid, if_instruction, if_pc, id_ready,
        output if_ready, id_valid, id_instruction, id_pc,
        output is_type_R, is_type_I, is_type_S, is_type_B, is_type_U, is_type_J,
        output id_illegal
    );

endinterface

// File: rtl/instr_classify.sv
// Combinational RV32 opcode-to-format classifier (one-hot R/I/S/B/U/J).
// Illegal-opcode flag is produced only when ILLEGAL_DETECT_EN is defined.
module instr_classify
    import atom_pkg::*;
(
    input  logic [XLEN-1:0] instr_i,
    output fmt_t            fmt_o,
    output logic            illegal_o
);

    logic unused_hi;
    assign unused_hi = ^instr_i[XLEN-1:7];

    always_comb begin
        fmt_o = '0;
        case (instr_i[6:0])
            OPC_OP:                                                fmt_o.r = 1'b1;
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_FENCE, OPC_SYSTEM: fmt_o.i = 1'b1;
            OPC_STORE:                                             fmt_o.s = 1'b1;
            OPC_BRANCH:                                            fmt_o.b = 1'b1;
            OPC_LUI, OPC_AUIPC:                                    fmt_o.u = 1'b1;
            OPC_JAL:                                               fmt_o.j = 1'b1;
            default: ;
        endcase
    end

`ifdef ILLEGAL_DETECT_EN
    assign illegal_o = (fmt_o == '0) || (instr_i[1:0] != 2'b11);
`else
    assign illegal_o = 1'b0;
`endif

endmodule

// File: rtl/decode_stage.sv
// RV32 instruction-decode stage: classify on entry, hold in a main output
// register backed by one skid entry so if_ready never depends on id_ready.
module decode_stage
    import atom_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    decode_stage_if.slave  bus
);

    occ_e   occ_q, occ_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    fmt_t   in_fmt;
    logic   in_illegal;
    logic   in_xfer;
    logic   out_xfer;

    instr_classify u_classify (
        .instr_i   (bus.if_instruction),
        .fmt_o     (in_fmt),
        .illegal_o (in_illegal)
    );

    assign in_entry = {bus.if_instruction, bus.if_pc, in_fmt, in_illegal};

    assign bus.if_ready = (occ_q != OCC_FULL);
    assign bus.id_valid = (occ_q != OCC_EMPTY);
    assign in_xfer      = bus.if_valid & bus.if_ready;
    assign out_xfer     = bus.id_valid & bus.id_ready;

    // Skid is only ever filled while main holds an unconsumed entry, and is
    // drained into main before if_ready can reopen, which keeps order intact.
    always_comb begin
        occ_d  = occ_q;
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
            occ_d = OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (in_xfer) begin
                        main_d = in_entry;
                        occ_d  = OCC_MAIN;
                    end
                end
                OCC_MAIN: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_entry;
                    end else if (in_xfer) begin
                        skid_d = in_entry;
                        occ_d  = OCC_FULL;
                    end else if (out_xfer) begin
                        occ_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (out_xfer) begin
                        main_d = skid_q;
                        occ_d  = OCC_MAIN;
                    end
                end
                default: occ_d = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= OCC_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            occ_q  <= occ_d;
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign bus.id_instruction = main_q.instr;
    assign bus.id_pc          = main_q.pc;
    assign bus.is_type_R      = main_q.fmt.r;
    assign bus.is_type_I      = main_q.fmt.i;
    assign bus.is_type_S      = main_q.fmt.s;
    assign bus.is_type_B      = main_q.fmt.b;
    assign bus.is_type_U      = main_q.fmt.u;
    assign bus.is_type_J      = main_q.fmt.j;
    assign bus.id_illegal     = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// run against a queue-based reference model. Honors ILLEGAL_DETECT_EN.
module tb_decode_stage;
    import atom_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    decode_stage_if bus ();

    decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } item_t;

    item_t q[$];

    logic [5:0] got_fmt;
    assign got_fmt = {bus.is_type_R, bus.is_type_I, bus.is_type_S,
                      bus.is_type_B, bus.is_type_U, bus.is_type_J};

    // Expected format as {R,I,S,B,U,J}, straight from the opcode table.
    function automatic logic [5:0] exp_fmt(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        if (op == 7'h33)                                      return 6'b100000;
        if (op inside {7'h03, 7'h13, 7'h67, 7'h0F, 7'h73})    return 6'b010000;
        if (op == 7'h23)                                      return 6'b001000;
        if (op == 7'h63)                                      return 6'b000100;
        if (op inside {7'h37, 7'h17})                         return 6'b000010;
        if (op == 7'h6F)                                      return 6'b000001;
        return 6'b000000;
    endfunction

    function automatic logic exp_illegal(input logic [31:0] w);
`ifdef ILLEGAL_DETECT_EN
        return (exp_fmt(w) == 6'b0) || (w[1:0] != 2'b11);
`else
        return (w == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, settle #1.
    task automatic cycle(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                         input bit r, input bit f, output bit acc);
        item_t it;
        bit    out;
        bus.if_valid       = v;
        bus.if_instruction = ins;
        bus.if_pc          = pc;
        bus.id_ready       = r;
        flush              = f;
        acc = v && (q.size() < 2) && !f;
        out = (q.size() != 0) && r;
        @(posedge clk);
        if (f) begin
            q.delete();
        end else begin
            if (out) q.delete(0);
            if (acc) begin
                it.ins = ins;
                it.pc  = pc;
                q.push_back(it);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        bus.if_valid = 1'b0;
        bus.if_instruction = '0;
        bus.if_pc = '0;
        bus.id_ready = 1'b0;
        #1;
        checks++;
        if (bus.id_valid !== 1'b0 || bus.if_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_hs got valid=%b ready=%b exp valid=0 ready=1", bus.id_valid, bus.if_ready);
        end
        checks++;
        if (bus.id_instruction !== 32'h0 || bus.id_pc !== 32'h0 || got_fmt !== 6'b0 || bus.id_illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_payload got ins=%h pc=%h fmt=%b ill=%b exp all zero",
                     bus.id_instruction, bus.id_pc, got_fmt, bus.id_illegal);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.id_valid !== 1'b0 || bus.if_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release got valid=%b ready=%b exp valid=0 ready=1", bus.id_valid, bus.if_ready);
        end
    endtask

    task automatic test_stream();
        logic [31:0] w[6] = '{32'h00500093, 32'h00112023, 32'hFE0008E3,
                              32'h000012B7, 32'h0100006F, 32'h002081B3};
        logic [5:0]  f[6] = '{6'b010000, 6'b001000, 6'b000100,
                              6'b000010, 6'b000001, 6'b100000};
        bit acc;
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, w[k], 32'(32'h100 + 4 * k), 1'b1, 1'b0, acc);
            checks++;
            if (bus.id_valid !== 1'b1 || bus.id_instruction !== w[k] || bus.id_pc !== 32'(32'h100 + 4 * k)) begin
                failures++;
                $display("FAIL stream_data[%0d] got v=%b ins=%h pc=%h exp v=1 ins=%h pc=%h",
                         k, bus.id_valid, bus.id_instruction, bus.id_pc, w[k], 32'(32'h100 + 4 * k));
            end
            checks++;
            if (got_fmt !== f[k] || bus.id_illegal !== 1'b0) begin
                failures++;
                $display("FAIL stream_fmt[%0d] got fmt=%b ill=%b exp fmt=%b ill=0", k, got_fmt, bus.id_illegal, f[k]);
            end
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
        checks++;
        if (bus.id_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_drain got valid=%b exp 0", bus.id_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] seq[6];
        int idx  = 0;
        int nout = 0;
        bit acc;
        for (int k = 0; k < 6; k++) seq[k] = 32'h0000_0013 | (32'(k + 1) << 20);
        for (int c = 0; c < 4; c++) begin
            cycle(1'b1, seq[idx], 32'(32'h200 + 4 * idx), 1'b0, 1'b0, acc);
            if (acc) idx++;
            if (c == 1) begin
                checks++;
                if (bus.if_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_ready_drop got if_ready=%b exp 0", bus.if_ready);
                end
            end
        end
        checks++;
        if (bus.id_valid !== 1'b1 || bus.id_instruction !== seq[0] || bus.if_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold got v=%b ins=%h rdy=%b exp v=1 ins=%h rdy=0",
                     bus.id_valid, bus.id_instruction, bus.if_ready, seq[0]);
        end
        for (int c = 0; c < 12; c++) begin
            if (bus.id_valid === 1'b1) begin
                checks++;
                if (nout >= 6 || bus.id_instruction !== seq[nout]) begin
                    failures++;
                    $display("FAIL bp_order[%0d] got ins=%h exp ins=%h", nout, bus.id_instruction,
                             (nout < 6) ? seq[nout] : 32'hx);
                end
                nout++;
            end
            if (idx < 6) begin
                cycle(1'b1, seq[idx], 32'(32'h200 + 4 * idx), 1'b1, 1'b0, acc);
                if (acc) idx++;
            end else begin
                cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
            end
        end
        checks++;
        if (nout != 6) begin
            failures++;
            $display("FAIL bp_count got delivered=%0d exp 6", nout);
        end
    endtask

    task automatic test_flush();
        bit acc;
        cycle(1'b1, 32'h00A00093, 32'h300, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h00B00093, 32'h304, 1'b0, 1'b0, acc);
        checks++;
        if (bus.if_ready !== 1'b0 || bus.id_valid !== 1'b1) begin
            failures++;
            $display("FAIL flush_prefill got rdy=%b v=%b exp rdy=0 v=1", bus.if_ready, bus.id_valid);
        end
        cycle(1'b1, 32'h00C00093, 32'h308, 1'b0, 1'b1, acc);
        checks++;
        if (bus.id_valid !== 1'b0 || bus.if_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_clear got v=%b rdy=%b exp v=0 rdy=1", bus.id_valid, bus.if_ready);
        end
        for (int c = 0; c < 3; c++) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
            checks++;
            if (bus.id_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_dropped[%0d] got v=%b ins=%h exp v=0", c, bus.id_valid, bus.id_instruction);
            end
        end
    endtask

    task automatic test_illegal();
        bit acc;
        cycle(1'b1, 32'h0000007F, 32'h400, 1'b1, 1'b0, acc);
        checks++;
        if (bus.id_valid !== 1'b1 || got_fmt !== 6'b0 || bus.id_illegal !== exp_illegal(32'h0000007F)) begin
            failures++;
            $display("FAIL illegal_word got v=%b fmt=%b ill=%b exp v=1 fmt=000000 ill=%b",
                     bus.id_valid, got_fmt, bus.id_illegal, exp_illegal(32'h0000007F));
        end
        cycle(1'b1, 32'h00000010, 32'h404, 1'b1, 1'b0, acc);
        checks++;
        if (got_fmt !== 6'b0 || bus.id_illegal !== exp_illegal(32'h00000010)) begin
            failures++;
            $display("FAIL illegal_lowbits got fmt=%b ill=%b exp fmt=000000 ill=%b",
                     got_fmt, bus.id_illegal, exp_illegal(32'h00000010));
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
    endtask

    task automatic test_async_reset();
        bit acc;
        cycle(1'b1, 32'h00D00093, 32'h500, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h00112023, 32'h504, 1'b0, 1'b0, acc);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        checks++;
        if (bus.id_valid !== 1'b0 || bus.if_ready !== 1'b1 || bus.id_instruction !== 32'h0 ||
            bus.id_pc !== 32'h0 || got_fmt !== 6'b0) begin
            failures++;
            $display("FAIL areset_immediate got v=%b rdy=%b ins=%h pc=%h fmt=%b exp v=0 rdy=1 zeros",
                     bus.id_valid, bus.if_ready, bus.id_instruction, bus.id_pc, got_fmt);
        end
        #1 rst_n = 1'b1;
        cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
        checks++;
        if (bus.id_valid !== 1'b0 || bus.if_ready !== 1'b1) begin
            failures++;
            $display("FAIL areset_release got v=%b rdy=%b exp v=0 rdy=1", bus.id_valid, bus.if_ready);
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops[11] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23,
                                 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
        logic [31:0] w;
        logic [31:0] pc;
        bit v, r, f, acc;
        bit    stalled = 1'b0;
        item_t held;
        for (int n = 0; n < 10000; n++) begin
            checks++;
            if (bus.id_valid !== (q.size() != 0) || bus.if_ready !== (q.size() < 2)) begin
                failures++;
                $display("FAIL rand_hs[%0d] got v=%b rdy=%b exp v=%b rdy=%b",
                         n, bus.id_valid, bus.if_ready, q.size() != 0, q.size() < 2);
            end
            if (q.size() != 0) begin
                checks++;
                if (bus.id_instruction !== q[0].ins || bus.id_pc !== q[0].pc ||
                    got_fmt !== exp_fmt(q[0].ins) || bus.id_illegal !== exp_illegal(q[0].ins)) begin
                    failures++;
                    $display("FAIL rand_data[%0d] got ins=%h pc=%h fmt=%b ill=%b exp ins=%h pc=%h fmt=%b ill=%b",
                             n, bus.id_instruction, bus.id_pc, got_fmt, bus.id_illegal,
                             q[0].ins, q[0].pc, exp_fmt(q[0].ins), exp_illegal(q[0].ins));
                end
            end
            if (stalled) begin
                checks++;
                if (bus.id_instruction !== held.ins || bus.id_pc !== held.pc) begin
                    failures++;
                    $display("FAIL rand_stable[%0d] got ins=%h pc=%h exp ins=%h pc=%h",
                             n, bus.id_instruction, bus.id_pc, held.ins, held.pc);
                end
            end
            v  = ($urandom_range(0, 9) < 7);
            r  = ($urandom_range(0, 9) < 6);
            f  = ($urandom_range(0, 99) < 2);
            w  = $urandom();
            pc = $urandom();
            if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 10)];
            stalled = (q.size() != 0) && !r && !f;
            if (stalled) held = q[0];
            cycle(v, w, pc, r, f, acc);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_illegal();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode pipeline stage for the RV32 core. Accepts fetched instructions over a valid/ready handshake, classifies each opcode into a one-hot instruction format (R/I/S/B/U/J), and registers the instruction, PC and format flags. It feeds the immediate generator and register-file read stage directly downstream. A two-entry skid buffer decouples fetch from downstream back-pressure without a combinational ready path.

## Interface
- XLEN, 32, datapath and instruction width
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- if_valid  input  1  fetch presents an instruction
- if_ready  output  1  stage can accept; registered, no combinational path from id_ready
- if_instruction  input  XLEN  fetched instruction word
- if_pc  input  XLEN  PC of fetched instruction
- flush  input  1  kill all held instructions (branch redirect/trap)
- id_valid  output  1  registered instruction available downstream
- id_ready  input  1  downstream accepts
- id_instruction  output  XLEN  held instruction
- id_pc  output  XLEN  held PC
- is_type_R, is_type_I, is_type_S, is_type_B, is_type_U, is_type_J  output  1 each  one-hot format flags, all 0 for illegal
- id_illegal  output  1  illegal opcode flag (only with ILLEGAL_DETECT_EN; tied 0 otherwise)

## Operation
- Classification on instruction[6:0]: 0110011→R; 0000011, 0010011, 1100111, 0001111, 1110011→I; 0100011→S; 1100011→B; 0110111, 0010111→U; 1101111→J; anything else → no flag set.
- Storage: output register (main) plus one skid register, each holding {instruction, pc, flags, illegal}.
- Input transfer: if_valid & if_ready. Output transfer: id_valid & id_ready.
- Input transfer with main empty, or main being consumed in the same cycle: write main.
- Input transfer with main full and not consumed: write skid; if_ready drops the next cycle.
- Output transfer with skid full: skid moves into main, skid empties, if_ready rises the next cycle.
- if_ready = !skid_valid, registered.
- Order preserved: skid content always precedes a newly arriving instruction.
- flush: main and skid valid bits cleared on the next edge; a simultaneous input transfer is dropped; if_ready = 1 the next cycle. Payload registers need not clear.

## Timing
- Reset (asynchronous, rst_n low): id_valid=0, skid empty, if_ready=1, id_instruction=0, id_pc=0, all is_type_*=0, id_illegal=0.
- Latency: instruction accepted at edge N is visible on id_* after edge N (1 cycle).
- Throughput: 1 instruction/cycle while id_ready=1.
- Back-pressure: at most one more instruction accepted after id_ready falls; no instruction is lost or duplicated.
- Reset asserted mid-stream discards all held instructions immediately.
- Outputs stable while id_valid=1 and id_ready=0.

## Configuration
- ILLEGAL_DETECT_EN defined: id_illegal=1 when opcode matches none of the listed values or instruction[1:0]≠2'b11. Flags remain all 0. The entry is still passed downstream, which raises the trap.
- Undefined: id_illegal is constant 0. Unknown opcodes pass with all flags 0, and the immediate generator yields 0.

## Structure
- Shared package atom_pkg: opcode localparams (OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_FENCE, OPC_SYSTEM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP) and a packed struct for the decoded entry.
- One combinational sub-module, instr_classify: instruction in, six flags plus illegal out. Instantiated once, on the input side.

## Test plan
- Stream 0x00500093 (addi), 0x00112023 (sw), 0xFE0008E3 (beq), 0x000012B7 (lui), 0x0100006F (jal), 0x002081B3 (add) with id_ready=1 → each appears 1 cycle later with exactly I, S, B, U, J, R set; id_valid continuous.
- id_ready=0 for 4 cycles during a continuous stream → exactly 2 instructions held; if_ready low from the cycle after the second; in-order release on id_ready=1, no loss or duplication.
- flush asserted with main and skid full and if_valid=1 → next cycle id_valid=0, if_ready=1; the dropped input never appears.
- Word 0x0000007F with ILLEGAL_DETECT_EN → id_illegal=1, all flags 0. Same word without the macro → id_illegal=0, flags 0.
- rst_n pulsed low mid-stream between edges → outputs zero immediately; after release if_ready=1 and id_valid=0.
- Random if_valid/id_ready (10k cycles) against a scoreboard → order and content match, and id_* stay stable under stall.
